// File: rtl/stream_accumulator.sv
// Streaming unsigned accumulator over a valid/ready port.
// Sums a programmed count of operands through a ripple-carry adder.
module sa_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sa_ripple_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_bit
    sa_fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end
  assign cout = c[N];
endmodule

module stream_accumulator #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_overflow,
  output logic             busy
);
  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [N-1:0]     add_sum;
  logic             add_cout;

  sa_ripple_adder #(.N(N)) u_add (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    rem_d     = rem_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_cout;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_stream_accumulator.sv
// Randomized self-checking bench for stream_accumulator.
// Expected results come from whole-job arithmetic on the operand list.
module tb_stream_accumulator;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_overflow;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ops [16];

  stream_accumulator #(.N(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-job reference: true sum of operands, wrapped; any carry
  // happens exactly when the true total leaves the N-bit range.
  task automatic model(input int n, output logic [7:0] s, output logic o);
    int tot;
    tot = 0;
    for (int i = 0; i < n; i++) tot += int'(ops[i]);
    s = 8'(tot % 256);
    o = (tot > 255);
  endtask

  task automatic run_job(
    input  int         n,
    input  int         gap,
    input  int         hold,
    input  bit         pulse,
    output logic [7:0] sum,
    output logic       ovf,
    output int         hs,
    output bit         lat_ok,
    output int         unstable,
    output bit         ir_seen,
    output logic       busy_after,
    output logic       ov_after,
    output logic [7:0] kept_sum,
    output bit         timeout
  );
    int idx, gapc;
    bit hsnow;
    logic [7:0] s0;
    logic o0;
    hs = 0; idx = 0; gapc = 0; lat_ok = 0;
    unstable = 0; ir_seen = 0; timeout = 1;
    start = 1'b1;
    len = 4'(n);
    if (in_ready) ir_seen = 1;
    step();
    start = 1'b0;
    if (n == 0) lat_ok = out_valid;
    for (int c = 0; c < 400; c++) begin
      if (out_valid) begin
        timeout = 0;
        break;
      end
      in_valid = (idx < n) && (gapc == 0);
      in_data = in_valid ? ops[idx] : 8'($urandom);
      if (pulse) begin
        start = 1'($urandom);
        len = 4'($urandom);
      end
      hsnow = in_valid && in_ready;
      if (in_ready) ir_seen = 1;
      step();
      if (hsnow) begin
        idx++;
        hs++;
        gapc = gap;
        if (idx == n) lat_ok = out_valid;
      end else if (gapc > 0) begin
        gapc--;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    s0 = out_sum;
    o0 = out_overflow;
    for (int c = 0; c < hold; c++) begin
      out_ready = 1'b0;
      if (in_ready) ir_seen = 1;
      step();
      if (!out_valid || out_sum !== s0 || out_overflow !== o0)
        unstable++;
    end
    out_ready = 1'b1;
    sum = out_sum;
    ovf = out_overflow;
    step();
    out_ready = 1'b0;
    busy_after = busy;
    ov_after = out_valid;
    kept_sum = out_sum;
  endtask

  logic [7:0] r_sum, r_kept;
  logic r_ovf, r_busy, r_ov;
  int r_hs, r_unst;
  bit r_lat, r_ir, r_to;

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy, out_overflow, out_sum} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0",
               {in_ready, out_valid, busy, out_overflow, out_sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30;
    run_job(3, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || r_sum !== 8'd60 || r_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_sum got=%0d/%b to=%0b want=60/0",
               r_sum, r_ovf, r_to);
    end
    n_checks++;
    if (!r_lat || r_hs != 3) begin
      n_fail++;
      $display("FAIL basic_latency lat_ok=%0b hs=%0d want=1/3", r_lat, r_hs);
    end
    n_checks++;
    if (r_busy !== 1'b0 || r_ov !== 1'b0 || r_kept !== 8'd60) begin
      n_fail++;
      $display("FAIL basic_after busy=%b ov=%b kept=%0d want=0/0/60",
               r_busy, r_ov, r_kept);
    end
  endtask

  task automatic test_overflow();
    ops[0] = 8'd200; ops[1] = 8'd100;
    run_job(2, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || r_sum !== 8'd44 || r_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_job got=%0d/%b want=44/1", r_sum, r_ovf);
    end
    ops[0] = 8'd5;
    run_job(1, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || r_sum !== 8'd5 || r_ovf !== 1'b0 || !r_lat) begin
      n_fail++;
      $display("FAIL ovf_clear got=%0d/%b lat=%0b want=5/0/1",
               r_sum, r_ovf, r_lat);
    end
  endtask

  task automatic test_zero_len();
    ops[0] = 8'd250; ops[1] = 8'd250;
    run_job(2, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    run_job(0, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || !r_lat || r_sum !== 8'd0 || r_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len got=%0d/%b lat=%0b want=0/0/1",
               r_sum, r_ovf, r_lat);
    end
    n_checks++;
    if (r_ir || r_hs != 0) begin
      n_fail++;
      $display("FAIL zero_len_ready ir_seen=%0b hs=%0d want=0/0", r_ir, r_hs);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 4; i++) ops[i] = 8'(i + 1);
    run_job(4, 2, 5, 1, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || r_sum !== 8'd10 || r_ovf !== 1'b0 || r_hs != 4) begin
      n_fail++;
      $display("FAIL gaps_sum got=%0d/%b hs=%0d want=10/0/4",
               r_sum, r_ovf, r_hs);
    end
    n_checks++;
    if (r_unst != 0 || !r_lat) begin
      n_fail++;
      $display("FAIL gaps_hold unstable=%0d lat=%0b want=0/1", r_unst, r_lat);
    end
  endtask

  task automatic test_midjob_reset();
    ops[0] = 8'd40; ops[1] = 8'd50;
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = ops[i];
      step();
    end
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, out_overflow, out_sum} !== 12'h0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=0",
               {in_ready, out_valid, busy, out_overflow, out_sum});
    end
    #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon ov=%b busy=%b want=0/0", out_valid, busy);
    end
    ops[0] = 8'd7;
    run_job(1, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || r_sum !== 8'd7 || r_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset got=%0d/%b want=7/0", r_sum, r_ovf);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 15; i++) ops[i] = 8'd255;
    run_job(15, 0, 0, 0, r_sum, r_ovf, r_hs, r_lat, r_unst,
            r_ir, r_busy, r_ov, r_kept, r_to);
    n_checks++;
    if (r_to || r_sum !== 8'd241 || r_ovf !== 1'b1 || r_hs != 15) begin
      n_fail++;
      $display("FAIL max_len got=%0d/%b hs=%0d want=241/1/15",
               r_sum, r_ovf, r_hs);
    end
  endtask

  task automatic test_random();
    logic [7:0] e_sum;
    logic e_ovf;
    int n;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 15);
      for (int i = 0; i < 16; i++)
        ops[i] = (j % 3 == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      model(n, e_sum, e_ovf);
      run_job(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom),
              r_sum, r_ovf, r_hs, r_lat, r_unst,
              r_ir, r_busy, r_ov, r_kept, r_to);
      n_checks++;
      if (r_to || r_sum !== e_sum || r_ovf !== e_ovf || r_hs != n
          || !r_lat || r_unst != 0 || r_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_job%0d n=%0d got=%0d/%b hs=%0d lat=%0b un=%0d want=%0d/%b",
                 j, n, r_sum, r_ovf, r_hs, r_lat, r_unst, e_sum, e_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_len();
    test_gaps();
    test_midjob_reset();
    test_max_len();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
